// File: rtl/dataflow_uart_tx_pkg.sv
// rtl/dataflow_uart_tx_pkg.sv - shared types and line levels for the UART transmitter
package dataflow_uart_tx_pkg;

    typedef enum logic [1:0] {
        IDLE,
        START,
        DATA,
        STOP
    } tx_state_e;

    localparam logic START_BIT  = 1'b0;
    localparam logic STOP_BIT   = 1'b1;
    localparam logic IDLE_LEVEL = 1'b1;

endpackage

// File: rtl/dataflow_uart_tx_if.sv
// rtl/dataflow_uart_tx_if.sv - parallel word in, serial line out
interface dataflow_uart_tx_if #(
    parameter int n = 8
);
    logic         start_sig;
    logic [n-1:0] D;
    logic         Tx;

    modport master (
        output start_sig,
        output D,
        input  Tx
    );

    modport slave (
        input  start_sig,
        input  D,
        output Tx
    );
endinterface

// File: rtl/dataflow_uart_baud_tick.sv
// rtl/dataflow_uart_baud_tick.sv - one-cycle tick at the end of every bit period
module dataflow_uart_baud_tick #(
    parameter int CLKS_PER_BIT = 1
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clear,
    output logic tick
);
    localparam int            CW   = $clog2(CLKS_PER_BIT + 1);
    localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    // Count cycles within a bit period; wrap at the last cycle, restart on frame acceptance.
    always_comb begin
        cnt_d = cnt_q + CW'(1);
        if (clear || (cnt_q == LAST)) begin
            cnt_d = '0;
        end
    end

    // Period counter register (rst_n is active-high here).
    always_ff @(posedge clk or posedge rst_n) begin
        if (rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    // With one clock per bit the counter stays at 0, so tick is permanently high.
    assign tick = (cnt_q == LAST);

endmodule

// File: rtl/dataflow_uart_tx.sv
// rtl/dataflow_uart_tx.sv - parallel-to-serial UART transmitter (start, n data LSB first, stop)
module dataflow_uart_tx
    import dataflow_uart_tx_pkg::*;
#(
    parameter int n            = 8,
    parameter int CLKS_PER_BIT = 1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    dataflow_uart_tx_if.slave    bus
);
    localparam int            BW       = $clog2(n + 1);
    localparam logic [BW-1:0] LAST_BIT = BW'(n - 1);

    tx_state_e     state_q, state_d;
    logic [n-1:0]  shift_q, shift_d;
    logic [BW-1:0] bit_cnt_q, bit_cnt_d;
    logic          tx_q, tx_d;
    logic [n-1:0]  shifted;
    logic          accept;
    logic          tick;

    dataflow_uart_baud_tick #(
        .CLKS_PER_BIT (CLKS_PER_BIT)
    ) u_baud (
        .clk   (clk),
        .rst_n (rst_n),
        .clear (accept),
        .tick  (tick)
    );

    // Shift register moved one place toward the LSB, refilled with idle ones.
    always_comb begin
        shifted        = shift_q >> 1;
        shifted[n-1]   = STOP_BIT;
    end

    // Frame sequencing: next state, next line level, and word acceptance.
    always_comb begin
        state_d   = state_q;
        shift_d   = shift_q;
        bit_cnt_d = bit_cnt_q;
        tx_d      = tx_q;
        accept    = 1'b0;

        case (state_q)
            IDLE: begin
                tx_d = IDLE_LEVEL;
                if (bus.start_sig) begin
                    accept = 1'b1;
                end
            end
            START: begin
                if (tick) begin
                    state_d   = DATA;
                    tx_d      = shift_q[0];
                    shift_d   = shifted;
                    bit_cnt_d = '0;
                end
            end
            DATA: begin
                if (tick) begin
                    if (bit_cnt_q == LAST_BIT) begin
                        state_d = STOP;
                        tx_d    = STOP_BIT;
                    end else begin
                        tx_d      = shift_q[0];
                        shift_d   = shifted;
                        bit_cnt_d = bit_cnt_q + BW'(1);
                    end
                end
            end
            STOP: begin
                if (tick) begin
                    if (bus.start_sig) begin
                        accept = 1'b1;
                    end else begin
                        state_d = IDLE;
                        tx_d    = IDLE_LEVEL;
                    end
                end
            end
            default: begin
                state_d = IDLE;
                tx_d    = IDLE_LEVEL;
            end
        endcase

        // A newly accepted word drives the start bit from the accepting edge.
        if (accept) begin
            state_d   = START;
            shift_d   = bus.D;
            bit_cnt_d = '0;
            tx_d      = START_BIT;
        end
    end

    // State, shift register, bit counter and registered line; reset forces the line idle at once.
    always_ff @(posedge clk or posedge rst_n) begin
        if (rst_n) begin
            state_q   <= IDLE;
            shift_q   <= '1;
            bit_cnt_q <= '0;
            tx_q      <= IDLE_LEVEL;
        end else begin
            state_q   <= state_d;
            shift_q   <= shift_d;
            bit_cnt_q <= bit_cnt_d;
            tx_q      <= tx_d;
        end
    end

    assign bus.Tx = tx_q;

endmodule

// File: tb/tb_dataflow_uart_tx.sv
// tb/tb_dataflow_uart_tx.sv - self-checking bench for dataflow_uart_tx
module tb_dataflow_uart_tx;

    typedef struct {
        bit         start;
        logic [7:0] d;
        bit         exp;
    } vec_t;

    logic clk = 1'b0;
    logic rst_n;
    int   checks = 0;
    int   errors = 0;
    bit   q1[$];
    bit   q4[$];
    bit   exp1;
    bit   exp4;
    vec_t tbl[$];

    dataflow_uart_tx_if #(.n(8)) bus1 ();
    dataflow_uart_tx_if #(.n(8)) bus4 ();

    dataflow_uart_tx #(.n(8), .CLKS_PER_BIT(1)) dut1 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus1)
    );

    dataflow_uart_tx #(.n(8), .CLKS_PER_BIT(4)) dut4 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus4)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: Tx=%b expected %b at %0t", name, act, exp, $time);
        end
    endtask

    // Reference: an accepted word becomes a list of line levels, each repeated c times.
    task automatic model_edge(inout bit q[$], input int c, input bit s,
                              input logic [7:0] d, output bit e);
        bit v;
        if (q.size() == 0 && s) begin
            for (int b = 0; b < 10; b++) begin
                if (b == 0)      v = 1'b0;
                else if (b == 9) v = 1'b1;
                else             v = d[b-1];
                repeat (c) q.push_back(v);
            end
        end
        e = (q.size() > 0) ? q.pop_front() : 1'b1;
    endtask

    task automatic step(input string tag);
        @(posedge clk);
        if (rst_n) begin
            q1.delete();
            q4.delete();
            exp1 = 1'b1;
            exp4 = 1'b1;
        end else begin
            model_edge(q1, 1, bus1.start_sig, bus1.D, exp1);
            model_edge(q4, 4, bus4.start_sig, bus4.D, exp4);
        end
        #1;
        check({tag, "_model_c1"}, bus1.Tx, exp1);
        check({tag, "_model_c4"}, bus4.Tx, exp4);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [0:9] f55, fa3, f0f, ff0, f81, f00;
        vec_t       v;
        f55 = 10'b0101010101;
        fa3 = 10'b0110001011;
        f0f = 10'b0111100001;
        ff0 = 10'b0000011111;
        f81 = 10'b0100000011;
        f00 = 10'b0000000001;

        rst_n          = 1'b1;
        bus1.start_sig = 1'b0;
        bus1.D         = 8'h00;
        bus4.start_sig = 1'b0;
        bus4.D         = 8'h00;

        #12;
        check("reset_tx_c1", bus1.Tx, 1'b1);
        check("reset_tx_c4", bus4.Tx, 1'b1);
        rst_n = 1'b0;
        step("post_reset");
        step("post_reset");

        // 1 ns reset pulse between edges
        #2;
        rst_n = 1'b1;
        #1;
        check("pulse_tx_c1", bus1.Tx, 1'b1);
        check("pulse_tx_c4", bus4.Tx, 1'b1);
        rst_n = 1'b0;
        for (int i = 0; i < 5; i++) begin
            step("idle");
            check("idle_hold", bus1.Tx, 1'b1);
        end

        // Table: single frame 0x55, then 0xA3 with ignored start and D change at cycle 4
        for (int i = 0; i < 12; i++) begin
            v.start = (i == 0);
            v.d     = 8'h55;
            v.exp   = (i < 10) ? f55[i] : 1'b1;
            tbl.push_back(v);
        end
        for (int i = 0; i < 12; i++) begin
            v.start = (i == 0 || i == 4);
            v.d     = (i < 4) ? 8'hA3 : 8'hFF;
            v.exp   = (i < 10) ? fa3[i] : 1'b1;
            tbl.push_back(v);
        end
        for (int i = 0; i < tbl.size(); i++) begin
            bus1.start_sig = tbl[i].start;
            bus1.D         = tbl[i].d;
            step("tbl");
            check($sformatf("tbl_%0d", i), bus1.Tx, tbl[i].exp);
        end
        bus1.start_sig = 1'b0;

        // Back-to-back frames with start held high
        bus1.start_sig = 1'b1;
        bus1.D         = 8'h0F;
        for (int i = 0; i < 20; i++) begin
            if (i == 1) bus1.D = 8'hF0;
            step("b2b");
            check($sformatf("b2b_%0d", i), bus1.Tx, (i < 10) ? f0f[i] : ff0[i-10]);
            if (i == 10) bus1.start_sig = 1'b0;
        end
        step("b2b_end");
        check("b2b_idle", bus1.Tx, 1'b1);

        // Reset during bit D3 of a 0x00 frame
        bus1.start_sig = 1'b1;
        bus1.D         = 8'h00;
        step("abort");
        bus1.start_sig = 1'b0;
        for (int i = 0; i < 4; i++) step("abort");
        check("abort_in_d3", bus1.Tx, 1'b0);
        #2;
        rst_n = 1'b1;
        #1;
        check("abort_async_tx", bus1.Tx, 1'b1);
        step("abort_rst");
        step("abort_rst");
        rst_n = 1'b0;
        step("abort_idle");
        check("abort_idle", bus1.Tx, 1'b1);
        bus1.start_sig = 1'b1;
        for (int i = 0; i < 11; i++) begin
            step("fresh");
            bus1.start_sig = 1'b0;
            check($sformatf("fresh_%0d", i), bus1.Tx, (i < 10) ? f00[i] : 1'b1);
        end

        // Divided baud, 4 clocks per bit
        bus4.start_sig = 1'b1;
        bus4.D         = 8'h81;
        for (int i = 0; i < 42; i++) begin
            step("div");
            bus4.start_sig = 1'b0;
            bus4.D         = 8'h3C;
            check($sformatf("div_%0d", i), bus4.Tx, (i < 40) ? f81[i/4] : 1'b1);
        end

        // Randomized traffic on both instances
        for (int i = 0; i < 400; i++) begin
            bus1.start_sig = ($urandom_range(0, 3) == 0);
            bus1.D         = 8'($urandom);
            bus4.start_sig = ($urandom_range(0, 3) == 0);
            bus4.D         = 8'($urandom);
            step("rand");
        end

        $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
        $finish;
    end

endmodule

// File: doc/dataflow_uart_tx.md
Name: dataflow_uart_tx

Overview:
- Parallel-to-serial UART-style transmitter.
- Accepts an n-bit word on a one-cycle start strobe and serialises it on the single line Tx.
- Frame: one start bit (0), n data bits LSB first, one stop bit (1).
- Sits between a parallel data source and the serial line; no receiver or flow control.

Parameters:
- n, 8: data word width in bits, ≥1.
- CLKS_PER_BIT, 1: clock cycles per serial bit period, ≥1. At the default there is no baud divider and one bit is sent per clock.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- rst_n  input  1  reset. One clock domain; reset is asynchronous and active-high. The port keeps the codebase name rst_n but is asserted when 1.
- start_sig  input  1  transmit request, sampled on the rising edge.
- D  input  n  data word, sampled only on the edge that accepts start_sig.
- Tx  output  1  serial line, registered, idles at 1.

Behaviour:
- Reset (asynchronous, while rst_n=1):
  - state=IDLE, Tx=1, shift register all ones, counters 0.
  - Reset asserted mid-frame aborts the frame immediately: Tx goes to 1 without waiting for a clock edge.
  - After release the block is IDLE and the next start_sig is accepted normally.
- States: IDLE, START, DATA, STOP.
- IDLE:
  - Tx=1.
  - start_sig=1 at an edge: capture D into the shift register, go to START, Tx=0 from that edge.
  - start_sig=0: stay in IDLE.
- START:
  - Tx=0 for CLKS_PER_BIT cycles, then DATA.
  - On entry to DATA, Tx=D[0].
- DATA:
  - Each bit is held CLKS_PER_BIT cycles.
  - At each bit-period end: shift right, Tx=next bit, bit counter +1.
  - After bit n-1 completes, go to STOP with Tx=1.
- STOP:
  - Tx=1 for CLKS_PER_BIT cycles.
  - At period end, if start_sig=1: load D and go to START, giving back-to-back frames with no idle gap.
  - At period end, if start_sig=0: go to IDLE.
- Latency: the first start bit appears on Tx at the accepting edge. The frame occupies exactly (n+2)*CLKS_PER_BIT cycles.
- start_sig in START or DATA, or in STOP before period end, is ignored. The frame in flight is not disturbed.
- Changes to D after acceptance have no effect on the frame.
- start_sig held high continuously produces back-to-back frames, re-sampling D at each stop-bit end.
- Bit counter width is $clog2(n+1).
- Baud counter width is $clog2(CLKS_PER_BIT+1) and wraps to 0 at CLKS_PER_BIT-1.
- No X on Tx at any time after reset.

Decomposition:
- Package dataflow_uart_tx_pkg holds:
  - state typedef tx_state_e {IDLE, START, DATA, STOP};
  - localparam-style constants START_BIT=1'b0, STOP_BIT=1'b1, IDLE_LEVEL=1'b1.
- One sub-module, dataflow_uart_baud_tick:
  - parameter CLKS_PER_BIT;
  - inputs clk, rst_n, clear;
  - output tick, a 1-cycle pulse every CLKS_PER_BIT cycles, restarted by clear on frame acceptance;
  - at CLKS_PER_BIT=1, tick is constantly 1.
- Top level holds the FSM, shift register and bit counter.

Test Plan:
- Reset: pulse rst_n high for 1 ns with no clock edge -> Tx=1 immediately. State IDLE, Tx stays 1 for 5 idle cycles with start_sig=0.
- Single frame, n=8, CLKS_PER_BIT=1: D=0x55, start_sig=1 for one cycle -> on successive edges Tx=0,1,0,1,0,1,0,1,0,1, then Tx=1 (idle) from cycle 11 onward.
- Ignored start and D changes: D=0xA3 accepted; pulse start_sig and change D=0xFF at cycle 4 -> frame unchanged: 0,1,1,0,0,0,1,0,1,1, then idle.
- Back-to-back frames: start_sig held 1, D=0x0F then 0xF0 at the second frame's load edge -> two consecutive 10-bit frames with no idle cycle. Second frame is 0,0,0,0,0,1,1,1,1,1.
- Reset mid-frame: D=0x00 accepted, rst_n asserted during bit D3 -> Tx=1 immediately. A new start after release sends a complete fresh frame.
- Divided baud, CLKS_PER_BIT=4: D=0x81 -> each bit held exactly 4 cycles, frame is 40 cycles: 0,1,0,0,0,0,0,0,1,1.
